// File: rtl/pssi_pkg.sv
// Shared types and helpers for the PSSI transmit path.
package pssi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned PSSI_BYTES_PER_WORD = 4;

  // Pick byte 'idx' of the outgoing order; idx 0 is the first byte on the bus.
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  idx,
                                          input logic        lsb_first);
    logic [1:0] pos;
    pos = lsb_first ? idx : ~idx;
    case (pos)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/pssi_tx_ctrl_sync_fifo.sv
// Sample FIFO with registered head-of-queue output: dout_o always holds the
// oldest stored word one cycle after it is written, so a pop can use it directly.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = dout_q;

  // Pointer/level update; the new head is bypassed from din_i when the
  // word being written lands at the head position.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    dout_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      dout_d   = '0;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer, level and head registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/pssi_tx_ctrl.sv
// PSSI transmit controller: buffers 32-bit samples and streams them as
// bytes to the STM32 PSSI port with RDY flow control and frame gaps.
module pssi_tx_ctrl
  import pssi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned FRAME_WORDS = 256,
  parameter bit          LSB_FIRST   = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [31:0]                   sample_i,
  input  logic                          sample_valid_i,
  output logic                          pssi_clk_o,
  output logic                          pssi_de_o,
  input  logic                          pssi_rdy_i,
  output logic [7:0]                    pssi_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          busy_o,
  output logic                          frame_done_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned WW = $clog2(FRAME_WORDS + 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            pclk_q, pclk_d;
  logic            rdy_meta_q, rdy_s_q;
  logic            accept_q, accept_d;
  logic [1:0]      idx_q, idx_d;
  logic [WW-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]     word_q, word_d;
  logic [7:0]      data_q, data_d;
  logic            de_q, de_d;
  logic            ovf_q, ovf_d;
  logic            frame_done_q, frame_done_d;

  logic            run, div_last, tick_rise, tick_fall;
  logic            start_word, flush;
  logic            fifo_push, fifo_pop;
  logic [31:0]     fifo_dout;
  logic            fifo_full, fifo_empty;

  assign run       = enable_i | (state_q != IDLE);
  assign div_last  = (div_cnt_q == DW'(CLK_DIV - 1));
  assign tick_rise = run & div_last & ~pclk_q;
  assign tick_fall = run & div_last & pclk_q;
  assign flush     = (state_q == IDLE) & ~enable_i;
  assign fifo_push = sample_valid_i & enable_i;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .push_i  (fifo_push),
    .din_i   (sample_i),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .level_o (fifo_level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // PSSI clock divider; parked low whenever the link is idle and disabled.
  always_comb begin
    div_cnt_d = div_cnt_q;
    pclk_d    = pclk_q;
    if (!run) begin
      div_cnt_d = '0;
      pclk_d    = 1'b0;
    end else if (div_last) begin
      div_cnt_d = '0;
      pclk_d    = ~pclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  // Byte sequencing FSM: samples acceptance on the rising tick, moves on the falling tick.
  always_comb begin
    state_d      = state_q;
    accept_d     = accept_q;
    idx_d        = idx_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    data_d       = data_q;
    de_d         = de_q;
    frame_done_d = 1'b0;
    start_word   = 1'b0;
    fifo_pop     = 1'b0;
    ovf_d        = ovf_q | (sample_valid_i & enable_i & fifo_full);

    if (tick_rise) accept_d = de_q & rdy_s_q;

    if (tick_fall) begin
      accept_d = 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (enable_i && !fifo_empty && rdy_s_q) begin
            start_word = 1'b1;
          end else begin
            state_d = IDLE;
            de_d    = 1'b0;
          end
        end
        SEND: begin
          if (accept_q) begin
            if (idx_q != 2'(PSSI_BYTES_PER_WORD - 1)) begin
              idx_d  = idx_q + 2'd1;
              data_d = byte_sel(word_q, idx_q + 2'd1, LSB_FIRST);
            end else if (word_cnt_q == WW'(FRAME_WORDS - 1)) begin
              frame_done_d = 1'b1;
              word_cnt_d   = '0;
              de_d         = 1'b0;
              state_d      = GAP;
            end else begin
              word_cnt_d = word_cnt_q + WW'(1);
              if (enable_i && !fifo_empty) begin
                start_word = 1'b1;
              end else begin
                de_d    = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          de_d    = 1'b0;
        end
      endcase
    end

    if (start_word) begin
      fifo_pop = 1'b1;
      word_d   = fifo_dout;
      data_d   = byte_sel(fifo_dout, 2'd0, LSB_FIRST);
      idx_d    = 2'd0;
      de_d     = 1'b1;
      state_d  = SEND;
    end

    // Disabled and idle: link state is discarded along with the FIFO contents.
    if (flush) begin
      word_cnt_d = '0;
      ovf_d      = 1'b0;
    end
  end

  // Two-flop synchronizer for the STM32 ready pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
    end else begin
      rdy_meta_q <= pssi_rdy_i;
      rdy_s_q    <= rdy_meta_q;
    end
  end

  // Divider, FSM and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      pclk_q       <= 1'b0;
      accept_q     <= 1'b0;
      idx_q        <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
      data_q       <= '0;
      de_q         <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      pclk_q       <= pclk_d;
      accept_q     <= accept_d;
      idx_q        <= idx_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      data_q       <= data_d;
      de_q         <= de_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pssi_clk_o   = pclk_q;
  assign pssi_de_o    = de_q;
  assign pssi_data_o  = data_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_done_q;

endmodule
